// File: rtl/pwl_pipe_pkg.sv
// Shared types, constants, saturation helper and ROM contents for the PWL evaluator.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pwl_pipe_pkg;

   localparam int N_CH     = 4;
   localparam int CH_W     = 2;
   localparam int N_SET    = 16;
   localparam int SET_W    = 4;
   localparam int IN_W     = 16;
   localparam int IN_PT    = 14;
   localparam int ADDR_W   = 4;
   localparam int ADDR_OFF = 256;
   localparam int SEG_W    = 8;
   localparam int OFF_W    = 18;
   localparam int SLP_W    = 18;
   localparam int SLP_PT   = 16;
   localparam int BIAS_W   = 18;
   localparam int OUT_W    = 18;
   localparam int OUT_PT   = 14;

   // Product carries IN_PT+SLP_PT fraction bits; drop down to OUT_PT.
   localparam int SHIFT   = IN_PT + SLP_PT - OUT_PT;
   // Two guard bits so offset+prod+bias cannot wrap before saturation.
   localparam int SUM_W   = OUT_W + 2;
   localparam int PROD_W  = SEG_W + 1 + SLP_W;
   localparam int ROM_AW  = SET_W + ADDR_W;
   localparam int ROM_DW  = OFF_W + SLP_W;

   localparam int ROM_SEG  = 0;
   localparam int ROM_BIAS = 1;

   typedef logic [IN_W-1:0]         pwl_in_t;
   typedef logic signed [OUT_W-1:0] pwl_out_t;
   typedef logic [CH_W-1:0]         pwl_ch_t;
   typedef logic [SET_W-1:0]        pwl_set_t;

   typedef struct packed {
      logic              valid;
      pwl_ch_t           ch;
      logic              clamp;
      logic [ADDR_W-1:0] idx;
      logic [SEG_W-1:0]  seg;
      pwl_set_t          setting;
   } pwl_stage_t;

   typedef struct packed {
      logic     sat;
      pwl_out_t val;
   } pwl_sat_t;

   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (OUT_W - 1)));

   function automatic pwl_sat_t pwl_sat(input logic signed [SUM_W-1:0] s);
      pwl_sat_t r;
      r.sat = 1'b1;
      if (s > SAT_MAX) begin
         r.val = OUT_W'(SAT_MAX);
      end else if (s < SAT_MIN) begin
         r.val = OUT_W'(SAT_MIN);
      end else begin
         r.sat = 1'b0;
         r.val = OUT_W'(s);
      end
      return r;
   endfunction

   // Segment table {offset, slope}, address {setting, index}.
   // Settings 2/3 hold extreme entries that drive the sum past either rail.
   function automatic logic [ROM_DW-1:0] pwl_seg_word(input logic [ROM_AW-1:0] a);
      logic signed [OFF_W-1:0] off;
      logic signed [SLP_W-1:0] slp;
      case (a[ROM_AW-1 -: SET_W])
         SET_W'(2): begin
            off = OFF_W'(131000);
            slp = SLP_W'(131071);
         end
         SET_W'(3): begin
            off = OFF_W'(-131072);
            slp = SLP_W'(-131072);
         end
         default: begin
            off = OFF_W'(int'(a[ADDR_W-1:0]) * 1024);
            slp = SLP_W'(65536);
         end
      endcase
      return {off, slp};
   endfunction

   function automatic logic [BIAS_W-1:0] pwl_bias_word(input pwl_set_t s);
      return (s == SET_W'(1)) ? BIAS_W'(100) : '0;
   endfunction

endpackage

// File: rtl/mymult.sv
// Signed full-width multiplier.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b signed operands; o_p signed full-precision product.
module mymult #(
   parameter int AW = 9,
   parameter int BW = 18
) (
   input  logic signed [AW-1:0]    i_a,
   input  logic signed [BW-1:0]    i_b,
   output logic signed [AW+BW-1:0] o_p
);
   assign o_p = i_a * i_b;
endmodule

// File: rtl/myrom.sv
// Synchronous-read ROM; contents selected by KIND from the package tables.
// Latency: 1 cycle address-to-data; no enable, hold data by holding the address.
// Backpressure: none; caller re-presents the address to keep the output steady.
// Ports: i_clk clock, i_addr read address, o_data registered read data.
module myrom
   import pwl_pipe_pkg::*;
#(
   parameter int AW   = 8,
   parameter int DW   = 36,
   parameter int KIND = 0
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] o_data
);
   logic [DW-1:0] w_word;
   logic [DW-1:0] r_data;

   generate
      if (KIND == ROM_SEG) begin : g_seg
         assign w_word = pwl_seg_word(i_addr);
      end else begin : g_bias
         assign w_word = pwl_bias_word(i_addr);
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      r_data <= w_word;
   end

   assign o_data = r_data;
endmodule

// File: rtl/pwl_pipe_clamp_index.sv
// Removes the table offset from the input, clamps to the table span, splits index/fraction.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data input sample; o_index segment index; o_seg in-segment fraction; o_clamp range hit.
module pwl_clamp_index
   import pwl_pipe_pkg::*;
(
   input  pwl_in_t           i_data,
   output logic [ADDR_W-1:0] o_index,
   output logic [SEG_W-1:0]  o_seg,
   output logic              o_clamp
);
   localparam logic [IN_W:0] ADDR_OFF_V = (IN_W + 1)'(ADDR_OFF);

   // Top bit of the widened difference is the sign.
   logic [IN_W:0] w_diff;
   assign w_diff = {1'b0, i_data} - ADDR_OFF_V;

   always_comb begin
      o_index = '0;
      o_seg   = '0;
      o_clamp = 1'b0;
      if (w_diff[IN_W]) begin
         o_clamp = 1'b1;
      end else if (|w_diff[IN_W-1:ADDR_W+SEG_W]) begin
         o_index = '1;
         o_seg   = '1;
         o_clamp = 1'b1;
      end else begin
         o_index = w_diff[ADDR_W+SEG_W-1:SEG_W];
         o_seg   = w_diff[SEG_W-1:0];
      end
   end
endmodule

// File: rtl/pwl_pipe.sv
// Multi-channel pipelined piecewise-linear evaluator with clamp and saturation.
// Latency: accept at edge k -> o_out_valid after edge k+3; one sample per cycle.
// Backpressure: single global enable (!out_valid || out_ready) freezes all stages.
// Ports: i_in_* sample in (valid/ready), i_cfg_* per-channel setting write,
//        o_out_* result out (valid/ready) with channel, clamp and saturation flags.
module pwl_pipe
   import pwl_pipe_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_in_valid,
   output logic     o_in_ready,
   input  pwl_in_t  i_in_data,
   input  pwl_ch_t  i_in_ch,
   input  logic     i_cfg_we,
   input  pwl_ch_t  i_cfg_ch,
   input  pwl_set_t i_cfg_setting,
   output logic     o_out_valid,
   input  logic     i_out_ready,
   output pwl_out_t o_out_data,
   output pwl_ch_t  o_out_ch,
   output logic     o_out_clamp,
   output logic     o_out_sat
);
   logic              w_en;
   logic [ADDR_W-1:0] w_idx;
   logic [SEG_W-1:0]  w_seg;
   logic              w_clamp;

   pwl_set_t   r_setting [N_CH];
   pwl_stage_t r_s1;
   pwl_stage_t r_s2;

   logic [ROM_AW-1:0]        w_rom_addr;
   pwl_set_t                 w_bias_addr;
   logic [ROM_DW-1:0]        w_seg_word;
   logic [BIAS_W-1:0]        w_bias_word;
   logic signed [OFF_W-1:0]  w_off;
   logic signed [SLP_W-1:0]  w_slp;
   logic signed [PROD_W-1:0] w_prod;

   logic                     r_s3_vld;
   pwl_ch_t                  r_s3_ch;
   logic                     r_s3_clamp;
   logic signed [SUM_W-1:0]  r_s3_prod;
   logic signed [OFF_W-1:0]  r_s3_off;
   logic signed [BIAS_W-1:0] r_s3_bias;
   logic signed [SUM_W-1:0]  w_sum;
   pwl_sat_t                 w_sat;

   logic     r_out_vld;
   pwl_out_t r_out_data;
   pwl_ch_t  r_out_ch;
   logic     r_out_clamp;
   logic     r_out_sat;

   assign w_en       = !r_out_vld || i_out_ready;
   assign o_in_ready = w_en && i_rst_n;

   pwl_clamp_index u_ci (
      .i_data  (i_in_data),
      .o_index (w_idx),
      .o_seg   (w_seg),
      .o_clamp (w_clamp)
   );

   // Setting is read before this cycle's write lands: a same-cycle sample sees the old value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_CH; i++) r_setting[i] <= '0;
      end else if (i_cfg_we) begin
         r_setting[i_cfg_ch] <= i_cfg_setting;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else if (w_en) begin
         r_s1.valid   <= i_in_valid;
         r_s1.ch      <= i_in_ch;
         r_s1.clamp   <= w_clamp;
         r_s1.idx     <= w_idx;
         r_s1.seg     <= w_seg;
         r_s1.setting <= r_setting[i_in_ch];
         r_s2         <= r_s1;
      end
   end

   // While stalled the ROMs re-read the address of the sample sitting in S2,
   // so their registered outputs stay matched to it.
   assign w_rom_addr  = w_en ? {r_s1.setting, r_s1.idx} : {r_s2.setting, r_s2.idx};
   assign w_bias_addr = w_en ? r_s1.setting : r_s2.setting;

   myrom #(.AW(ROM_AW), .DW(ROM_DW), .KIND(ROM_SEG)) u_seg_rom (
      .i_clk  (i_clk),
      .i_addr (w_rom_addr),
      .o_data (w_seg_word)
   );

   myrom #(.AW(SET_W), .DW(BIAS_W), .KIND(ROM_BIAS)) u_bias_rom (
      .i_clk  (i_clk),
      .i_addr (w_bias_addr),
      .o_data (w_bias_word)
   );

   assign w_off = w_seg_word[ROM_DW-1 -: OFF_W];
   assign w_slp = w_seg_word[SLP_W-1:0];

   mymult #(.AW(SEG_W + 1), .BW(SLP_W)) u_mult (
      .i_a ($signed({1'b0, r_s2.seg})),
      .i_b (w_slp),
      .o_p (w_prod)
   );

   assign w_sum = SUM_W'(r_s3_off) + r_s3_prod + SUM_W'(r_s3_bias);
   assign w_sat = pwl_sat(w_sum);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s3_vld    <= 1'b0;
         r_s3_ch     <= '0;
         r_s3_clamp  <= 1'b0;
         r_s3_prod   <= '0;
         r_s3_off    <= '0;
         r_s3_bias   <= '0;
         r_out_vld   <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_clamp <= 1'b0;
         r_out_sat   <= 1'b0;
      end else if (w_en) begin
         r_s3_vld    <= r_s2.valid;
         r_s3_ch     <= r_s2.ch;
         r_s3_clamp  <= r_s2.clamp;
         // Arithmetic shift floors toward -inf.
         r_s3_prod   <= SUM_W'(w_prod >>> SHIFT);
         r_s3_off    <= w_off;
         r_s3_bias   <= w_bias_word;
         r_out_vld   <= r_s3_vld;
         r_out_data  <= w_sat.val;
         r_out_ch    <= r_s3_ch;
         r_out_clamp <= r_s3_clamp;
         r_out_sat   <= w_sat.sat;
      end
   end

   assign o_out_valid = r_out_vld;
   assign o_out_data  = r_out_data;
   assign o_out_ch    = r_out_ch;
   assign o_out_clamp = r_out_clamp;
   assign o_out_sat   = r_out_sat;
endmodule
